// File: rtl/meas_sched_pkg.sv
// rtl/meas_sched_pkg.sv - shared state encoding and averaging depth for meas_sched
package meas_sched_pkg;

   localparam int AVG_DEPTH = 4;

   typedef enum logic [2:0] {
      IDLE,
      MEAS_START,
      MEAS_WAIT,
      CONV_START,
      CONV_WAIT,
      DISP_WAIT,
      WAIT_PERIOD
   } t_meas_sched_state;

endpackage

// File: rtl/meas_avg.sv
// rtl/meas_avg.sv - 4-deep running average of one sensor channel
// avg_o already reflects a sample being pushed this cycle, so the caller can use it immediately.
module meas_avg
   import meas_sched_pkg::*;
#(
   parameter int DATA_BITS = 8
) (
   input  logic                 clk_i,
   input  logic                 resetn_i,
   input  logic                 push_i,
   input  logic [DATA_BITS-1:0] din_i,
   output logic [DATA_BITS-1:0] avg_o
);

   localparam int SW = DATA_BITS + 2;
   localparam int SH = $clog2(AVG_DEPTH);

   logic [DATA_BITS-1:0] win_q [AVG_DEPTH];
   logic [SW-1:0]        sum_q;
   logic [SW-1:0]        sum_d;
   logic                 primed_q;

   // First sample after reset fills the whole window so the average starts at that value.
   always_comb begin
      sum_d = sum_q;
      if (push_i) begin
         if (primed_q) begin
            sum_d = sum_q - SW'(win_q[AVG_DEPTH-1]) + SW'(din_i);
         end else begin
            sum_d = SW'(din_i) << SH;
         end
      end
   end

   assign avg_o = DATA_BITS'(sum_d >> SH);

   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         primed_q <= 1'b0;
         sum_q    <= '0;
         for (int i = 0; i < AVG_DEPTH; i++) begin
            win_q[i] <= '0;
         end
      end else if (push_i) begin
         primed_q <= 1'b1;
         sum_q    <= sum_d;
         for (int i = 0; i < AVG_DEPTH; i++) begin
            if (!primed_q || i == 0) begin
               win_q[i] <= din_i;
            end else begin
               win_q[i] <= win_q[i-1];
            end
         end
      end
   end

endmodule

// File: rtl/meas_sched.sv
// rtl/meas_sched.sv - sensor -> BCD -> LED display measurement scheduler
// Define MEAS_SCHED_AVG_EN to display 4-sample averages instead of raw sensor words.
module meas_sched
   import meas_sched_pkg::*;
#(
   parameter int MAIN_CLK       = 27_000_000,
   parameter int UPDATE_HZ      = 2,
   parameter int TIMEOUT_CYCLES = 2_700_000,
   parameter int DATA_BITS      = 8
) (
   input  logic                 in_clk,
   input  logic                 in_rst,
   input  logic                 in_enable,
   input  logic                 in_pause,
   input  logic                 in_sel_humid,
   input  logic                 in_show_hex,
   output logic                 out_meas_start,
   input  logic                 in_meas_done,
   input  logic                 in_meas_err,
   input  logic [DATA_BITS-1:0] in_temp,
   input  logic [DATA_BITS-1:0] in_humid,
   output logic                 out_conv_start,
   output logic [DATA_BITS-1:0] out_conv_num,
   input  logic                 in_conv_finished,
   input  logic [31:0]          in_conv_bcd,
   input  logic                 in_disp_ready,
   output logic                 out_disp_update,
   output logic [31:0]          out_disp_data,
   output logic                 out_busy,
   output logic                 out_error,
   output logic [7:0]           out_err_count
);

   localparam int PERIOD = MAIN_CLK / UPDATE_HZ;
   localparam int PW     = $clog2(PERIOD + 1);
   localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [PW-1:0] PERIOD_MAX  = PW'(PERIOD - 1);
   localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES - 1);

   t_meas_sched_state    state_q;
   logic [PW-1:0]        period_q;
   logic [TW-1:0]        timeout_q;
   logic                 meas_start_q;
   logic                 conv_start_q;
   logic [DATA_BITS-1:0] conv_num_q;
   logic                 disp_update_q;
   logic [31:0]          disp_data_q;
   logic                 error_q;
   logic [7:0]           err_count_q;

   logic                 meas_ok;
   logic                 fail;
   logic [DATA_BITS-1:0] temp_word;
   logic [DATA_BITS-1:0] humid_word;
   logic [DATA_BITS-1:0] sel_word;

   assign meas_ok = (state_q == MEAS_WAIT) && in_meas_done && !in_meas_err;

   // A sensor answer in the last timeout cycle still counts as an answer.
   assign fail = ((state_q == MEAS_WAIT) &&
                  (in_meas_done ? in_meas_err : (timeout_q == TIMEOUT_MAX))) ||
                 ((state_q == CONV_WAIT) && !in_conv_finished && (timeout_q == TIMEOUT_MAX));

`ifdef MEAS_SCHED_AVG_EN
   meas_avg #(.DATA_BITS(DATA_BITS)) u_avg_temp (
      .clk_i    (in_clk),
      .resetn_i (in_rst),
      .push_i   (meas_ok),
      .din_i    (in_temp),
      .avg_o    (temp_word)
   );

   meas_avg #(.DATA_BITS(DATA_BITS)) u_avg_humid (
      .clk_i    (in_clk),
      .resetn_i (in_rst),
      .push_i   (meas_ok),
      .din_i    (in_humid),
      .avg_o    (humid_word)
   );
`else
   logic [DATA_BITS-1:0] temp_q;
   logic [DATA_BITS-1:0] humid_q;

   always_ff @(posedge in_clk) begin
      if (!in_rst) begin
         temp_q  <= '0;
         humid_q <= '0;
      end else if (meas_ok) begin
         temp_q  <= in_temp;
         humid_q <= in_humid;
      end
   end

   assign temp_word  = meas_ok ? in_temp  : temp_q;
   assign humid_word = meas_ok ? in_humid : humid_q;
`endif

   assign sel_word = in_sel_humid ? humid_word : temp_word;

   always_ff @(posedge in_clk) begin
      if (!in_rst) begin
         state_q       <= IDLE;
         period_q      <= '0;
         timeout_q     <= '0;
         meas_start_q  <= 1'b0;
         conv_start_q  <= 1'b0;
         conv_num_q    <= '0;
         disp_update_q <= 1'b0;
         disp_data_q   <= '0;
         error_q       <= 1'b0;
         err_count_q   <= '0;
      end else begin
         meas_start_q  <= 1'b0;
         conv_start_q  <= 1'b0;
         disp_update_q <= 1'b0;

         if (period_q != PERIOD_MAX) begin
            period_q <= period_q + PW'(1);
         end
         if (state_q == MEAS_WAIT || state_q == CONV_WAIT) begin
            timeout_q <= timeout_q + TW'(1);
         end else begin
            timeout_q <= '0;
         end

         if (fail) begin
            error_q <= 1'b1;
            if (err_count_q != 8'hFF) begin
               err_count_q <= err_count_q + 8'd1;
            end
         end

         // The period counter restarts on entry so MEAS_START sees count 0.
         case (state_q)
            IDLE: begin
               if (in_enable) begin
                  state_q      <= MEAS_START;
                  meas_start_q <= 1'b1;
                  period_q     <= '0;
               end
            end
            MEAS_START: state_q <= MEAS_WAIT;
            MEAS_WAIT: begin
               if (meas_ok) begin
                  if (in_show_hex) begin
                     disp_data_q <= 32'(sel_word);
                     state_q     <= DISP_WAIT;
                  end else begin
                     state_q <= CONV_START;
                  end
               end else if (fail) begin
                  state_q <= WAIT_PERIOD;
               end
            end
            CONV_START: begin
               conv_num_q   <= sel_word;
               conv_start_q <= 1'b1;
               state_q      <= CONV_WAIT;
            end
            CONV_WAIT: begin
               if (in_conv_finished) begin
                  disp_data_q <= in_conv_bcd;
                  state_q     <= DISP_WAIT;
               end else if (fail) begin
                  state_q <= WAIT_PERIOD;
               end
            end
            DISP_WAIT: begin
               if (in_disp_ready) begin
                  disp_update_q <= 1'b1;
                  error_q       <= 1'b0;
                  state_q       <= WAIT_PERIOD;
               end
            end
            WAIT_PERIOD: begin
               if (!in_enable) begin
                  state_q <= IDLE;
               end else if (!in_pause && period_q == PERIOD_MAX) begin
                  state_q      <= MEAS_START;
                  meas_start_q <= 1'b1;
                  period_q     <= '0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign out_meas_start  = meas_start_q;
   assign out_conv_start  = conv_start_q;
   assign out_conv_num    = conv_num_q;
   assign out_disp_update = disp_update_q;
   assign out_disp_data   = disp_data_q;
   assign out_busy        = (state_q != IDLE) && (state_q != WAIT_PERIOD);
   assign out_error       = error_q;
   assign out_err_count   = err_count_q;

endmodule

// File: doc/meas_sched.md
MEAS_SCHED -- requirements
Module: meas_sched

Interface
REQ-001 The block SHALL have these parameters:
- MAIN_CLK, 27_000_000, main clock frequency in Hz.
- UPDATE_HZ, 2, measurement rate in Hz.
- TIMEOUT_CYCLES, 2_700_000, maximum wait for the sensor or the converter.
- DATA_BITS, 8, sensor word width.
REQ-002 The block SHALL have one clock, in_clk; reset in_rst SHALL be synchronous and active-low.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- in_clk, in, 1, clock.
- in_rst, in, 1, synchronous active-low reset.
- in_enable, in, 1, run scheduler.
- in_pause, in, 1, hold display (skip new cycles).
- in_sel_humid, in, 1, 1 selects humidity, 0 selects temperature.
- in_show_hex, in, 1, bypass BCD conversion.
- out_meas_start, out, 1, sensor start pulse.
- in_meas_done, in, 1, sensor result valid.
- in_meas_err, in, 1, sensor error (checksum or bus), qualified by in_meas_done.
- in_temp / in_humid, in, DATA_BITS, sensor words.
- out_conv_start, out, 1, BCD start pulse.
- out_conv_num, out, DATA_BITS, BCD input.
- in_conv_finished, in, 1, BCD done.
- in_conv_bcd, in, 32, BCD result.
- in_disp_ready, in, 1, LED matrix can accept an update.
- out_disp_update, out, 1, display update pulse.
- out_disp_data, out, 32, displayed digits.
- out_busy, out, 1, state is not IDLE or WAIT_PERIOD.
- out_error, out, 1, last cycle failed.
- out_err_count, out, 8, failures, saturating.

Function
REQ-004 States SHALL be IDLE, MEAS_START, MEAS_WAIT, CONV_START, CONV_WAIT, DISP_WAIT, WAIT_PERIOD.
REQ-005 IDLE: when in_enable=1, the block SHALL go to MEAS_START on the next edge, with no period wait.
REQ-006 MEAS_START: out_meas_start SHALL be 1 for exactly one cycle; the period and timeout counters SHALL clear; next state MEAS_WAIT.
REQ-007 MEAS_WAIT: on in_meas_done=1 with in_meas_err=0, the block SHALL latch in_temp/in_humid; if in_show_hex=0, next state CONV_START, otherwise DISP_WAIT with out_disp_data = zero-extended selected word.
REQ-008 MEAS_WAIT: in_meas_done=1 with in_meas_err=1, or timeout count reaching TIMEOUT_CYCLES-1, SHALL be a failure; in_meas_done wins over a same-cycle timeout.
REQ-009 CONV_START: in_sel_humid SHALL be sampled; out_conv_num SHALL be set to the selected word; out_conv_start SHALL pulse for one cycle; next state CONV_WAIT with the timeout counter cleared.
REQ-010 CONV_WAIT: in_conv_finished=1 SHALL latch in_conv_bcd into out_disp_data and go to DISP_WAIT; timeout SHALL be a failure.
REQ-011 DISP_WAIT: out_disp_data SHALL be stable; out_disp_update SHALL pulse for one cycle in the first cycle with in_disp_ready=1; out_error SHALL clear; next state WAIT_PERIOD.
REQ-012 Failure handling:
- out_error SHALL set.
- out_err_count SHALL increment, saturating at 255.
- out_disp_data SHALL be unchanged and no update SHALL be issued.
- next state WAIT_PERIOD.
REQ-013 The period counter SHALL run from MEAS_START, with PERIOD = MAIN_CLK/UPDATE_HZ cycles, and SHALL saturate at PERIOD-1.
REQ-014 WAIT_PERIOD behaviour:
- in_enable=0 SHALL go to IDLE.
- count=PERIOD-1 with in_pause=0 SHALL go to MEAS_START, so starts are PERIOD cycles apart when the cycle is shorter than PERIOD, and immediate otherwise.
- in_pause=1 SHALL hold in WAIT_PERIOD.
REQ-015 in_enable falling mid-cycle SHALL NOT abort; the current cycle SHALL complete and then go to IDLE.

Reset
REQ-016 While in_rst=0 at a clock edge:
- state SHALL be IDLE.
- all outputs, counters, latched words, out_err_count and the averaging window SHALL be 0.
- reset SHALL take effect from any state, and no start pulse SHALL be emitted in the reset cycle.

Configuration
REQ-017 With MEAS_SCHED_AVG_EN defined, each successful measurement SHALL push both channels into 4-deep windows.
- The first valid sample after reset SHALL preload all 4 entries.
- The sum SHALL be DATA_BITS+2 bits; the average SHALL be sum>>2, truncated.
- The averages SHALL replace the raw words in REQ-007 and REQ-009.
- Failures SHALL NOT enter the windows.
REQ-018 Without MEAS_SCHED_AVG_EN, the raw latched words SHALL be used and no window logic SHALL exist.

Structure
REQ-019 Package meas_sched_pkg SHALL hold the state enum t_meas_sched_state and the window depth constant AVG_DEPTH=4.
REQ-020 Averaging SHALL be a sub-module meas_avg, instantiated twice and only under MEAS_SCHED_AVG_EN.

Verification
REQ-021 Bench parameters SHALL be MAIN_CLK=1000, UPDATE_HZ=10 (PERIOD=100) and TIMEOUT_CYCLES=20. The bench SHALL cover these scenarios:
- Reset with in_enable=1: all outputs 0; after release, out_meas_start SHALL pulse on the first clock edge after release.
- Normal cycle, temp=23: out_conv_num=23; bcd 0x00000023 -> out_disp_data=0x00000023, one out_disp_update; the next out_meas_start SHALL come exactly 100 cycles after the previous one.
- No in_meas_done for 20 cycles: out_error=1, out_err_count=1, no update; next start at cycle 100; a following good cycle SHALL clear out_error.
- in_show_hex=1, in_sel_humid=1, humid=0x41: no out_conv_start; out_disp_data=0x00000041.
- in_disp_ready low for 30 cycles: the update pulse SHALL occur only once ready rises; in_enable dropped during MEAS_WAIT: the cycle completes, then IDLE with no further start.
- MEAS_SCHED_AVG_EN, temps 20, 24, 28, 32: out_conv_num SHALL be 20, 21, 23, 26.
